// File: rtl/fifo_sched_pkg.sv
// Shared defaults, occupancy width and read-FSM state encoding for the FIFO port scheduler.
package fifo_sched_pkg;

   localparam int DW_DEF    = 4;
   localparam int DEPTH_DEF = 8;
   localparam int LVL_W     = $clog2(DEPTH_DEF + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } rd_state_t;

   // Index of the winning requester: a lone requester wins, a tie goes to ptr.
   function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
      return (req[1] & ~req[0]) | (req[1] & req[0] & ptr);
   endfunction

endpackage

// File: rtl/fifo_port_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when a grant is accepted.
module rr_arb2
   import fifo_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt,
   output logic       winner
);

   logic rr_ptr_reg;

   assign winner = rr_pick(req, rr_ptr_reg);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
         assign gnt[gi] = req[gi] & (winner == 1'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_reg <= 1'b0;
      end else if (accept && (req != 2'b00)) begin
         rr_ptr_reg <= ~winner;
      end
   end

endmodule

// File: rtl/fifo_port_scheduler.sv
// Arbitrates two producers onto a shared FIFO write port, drains the read port into a
// registered valid/ready stage, and cross-checks its own occupancy against the FIFO flags.
module fifo_port_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic                         p0_valid,
   input  logic [DW-1:0]                p0_data,
   output logic                         p0_ready,
   input  logic                         p1_valid,
   input  logic [DW-1:0]                p1_data,
   output logic                         p1_ready,
   output logic                         fifo_wr_en,
   output logic [DW-1:0]                fifo_wr_data,
   input  logic                         fifo_full,
   output logic                         fifo_rd_en,
   input  logic [DW-1:0]                fifo_rd_data,
   input  logic                         fifo_empty,
   output logic                         m_valid,
   output logic [DW-1:0]                m_data,
   input  logic                         m_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         sync_err
);

   localparam int            LW      = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

   logic [LW-1:0] level_reg;
   rd_state_t     rd_state_reg;
   logic          m_valid_reg;
   logic [DW-1:0] m_data_reg;
   logic          sync_err_reg;

   logic [1:0]    req;
   logic [1:0]    gnt;
   logic          winner;
   logic          can_wr;
   logic          rd_allow;

   // rst_n is active-high here; it gates every strobe so nothing escapes during reset.
   assign can_wr   = ~rst_n & ena & ~fifo_full & (level_reg < LVL_MAX);
   assign rd_allow = ~rst_n & ena & ~fifo_empty & (level_reg != '0);
   assign req      = {p1_valid, p0_valid};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst_n),
      .req    (req),
      .accept (can_wr),
      .gnt    (gnt),
      .winner (winner)
   );

   assign p0_ready     = gnt[0] & can_wr;
   assign p1_ready     = gnt[1] & can_wr;
   assign fifo_wr_en   = can_wr & (req != 2'b00);
   assign fifo_wr_data = winner ? p1_data : p0_data;

   assign fifo_rd_en = ((rd_state_reg == IDLE) & rd_allow) |
                       ((rd_state_reg == HOLD) & m_ready & rd_allow);

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         level_reg <= '0;
      end else begin
         case ({fifo_wr_en, fifo_rd_en})
            2'b10:   if (level_reg != LVL_MAX) level_reg <= level_reg + 1'b1;
            2'b01:   if (level_reg != '0)      level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sync_err_reg <= 1'b0;
      end else if (((level_reg == LVL_MAX) != fifo_full) ||
                   ((level_reg == '0) != fifo_empty)) begin
         sync_err_reg <= 1'b1;
      end
   end

   // FETCH captures the word the FIFO returns one cycle after the read strobe.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rd_state_reg <= IDLE;
         m_valid_reg  <= 1'b0;
         m_data_reg   <= '0;
      end else begin
         case (rd_state_reg)
            IDLE: begin
               if (rd_allow) rd_state_reg <= FETCH;
            end
            FETCH: begin
               m_data_reg   <= fifo_rd_data;
               m_valid_reg  <= 1'b1;
               rd_state_reg <= HOLD;
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid_reg  <= 1'b0;
                  rd_state_reg <= rd_allow ? FETCH : IDLE;
               end
            end
            default: begin
               m_valid_reg  <= 1'b0;
               rd_state_reg <= IDLE;
            end
         endcase
      end
   end

   assign level    = level_reg;
   assign m_valid  = m_valid_reg;
   assign m_data   = m_data_reg;
   assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Directed bench for fifo_port_scheduler with a behavioural 8-deep FIFO and an output scoreboard.
module tb_fifo_port_scheduler;
   import fifo_sched_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ena;
   logic             p0_valid, p1_valid;
   logic [3:0]       p0_data, p1_data;
   logic             p0_ready, p1_ready;
   logic             fifo_wr_en, fifo_rd_en;
   logic [3:0]       fifo_wr_data;
   logic             fifo_full, fifo_empty;
   logic             m_valid, m_ready;
   logic [3:0]       m_data;
   logic [LVL_W-1:0] level;
   logic             sync_err;

   logic             fe_force = 1'b0;
   logic             fe_val   = 1'b0;
   logic [3:0]       mem [8];
   int               wp = 0, rp = 0, cnt = 0;
   logic [3:0]       rdata = 4'h0;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [3:0]       sb [$];

   always #5 clk = ~clk;

   fifo_port_scheduler #(.DEPTH(8), .DW(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .p0_valid     (p0_valid),
      .p0_data      (p0_data),
      .p0_ready     (p0_ready),
      .p1_valid     (p1_valid),
      .p1_data      (p1_data),
      .p1_ready     (p1_ready),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_full    (fifo_full),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (rdata),
      .fifo_empty   (fifo_empty),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .level        (level),
      .sync_err     (sync_err)
   );

   // Behavioural FIFO: read data returns one cycle after fifo_rd_en.
   always @(posedge clk) begin
      if (rst_n) begin
         wp <= 0; rp <= 0; cnt <= 0; rdata <= 4'h0;
      end else begin
         if (fifo_wr_en) begin
            mem[wp] <= fifo_wr_data;
            wp <= (wp + 1) % 8;
         end
         if (fifo_rd_en) begin
            rdata <= mem[rp];
            rp <= (rp + 1) % 8;
         end
         cnt <= cnt + int'(fifo_wr_en) - int'(fifo_rd_en);
      end
   end

   assign fifo_full  = (cnt == 8);
   assign fifo_empty = fe_force ? fe_val : (cnt == 0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops the scoreboard on any handshake in the current cycle, then advances one clock.
   task automatic tick();
      logic [3:0] exp_w;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(m_data), 32'hFFFF_FFFF);
         end else begin
            exp_w = sb.pop_front();
            chk("m_data_out", 32'(m_data), 32'(exp_w));
            $display("handshake: m_data=%0h expected=%0h", m_data, exp_w);
         end
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      int exp_lvl;
      logic er;

      // 1. reset hold with a pending producer and a non-empty flag
      rst_n = 1'b1; ena = 1'b1; m_ready = 1'b0;
      p0_valid = 1'b1; p0_data = 4'h5; p1_valid = 1'b0; p1_data = 4'h0;
      fe_force = 1'b1; fe_val = 1'b0;
      tick(); tick();
      #1;
      chk("rst_p0_ready", 32'(p0_ready), 0);
      chk("rst_p1_ready", 32'(p1_ready), 0);
      chk("rst_wr_en", 32'(fifo_wr_en), 0);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_sync_err", 32'(sync_err), 0);

      rst_n = 1'b0; fe_force = 1'b0;
      #1;
      chk("rel_p0_ready", 32'(p0_ready), 1);
      chk("rel_wr_data", 32'(fifo_wr_data), 32'h5);
      chk("rel_rd_en", 32'(fifo_rd_en), 0);
      sb.push_back(4'h5);
      $display("write: p0 data=5");
      tick();
      p0_valid = 1'b0; p1_valid = 1'b1; p1_data = 4'h6;
      #1;
      chk("lone_p1_ready", 32'(p1_ready), 1);
      chk("lone_wr_data", 32'(fifo_wr_data), 32'h6);
      chk("first_rd_en", 32'(fifo_rd_en), 1);
      sb.push_back(4'h6);
      $display("write: p1 data=6 with read");
      tick();
      p1_valid = 1'b0;
      #1;
      chk("wr_rd_level", 32'(level), 1);
      tick();

      // 2. round robin with both producers valid
      p0_valid = 1'b1; p0_data = 4'hA; p1_valid = 1'b1; p1_data = 4'hC;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_p0_ready", 32'(p0_ready), 32'(i % 2 == 0));
         chk("rr_p1_ready", 32'(p1_ready), 32'(i % 2 == 1));
         chk("rr_wr_data", 32'(fifo_wr_data), (i % 2 == 0) ? 32'hA : 32'hC);
         sb.push_back((i % 2 == 0) ? 4'hA : 4'hC);
         $display("rr write %0d: data=%0h", i, fifo_wr_data);
         tick();
      end
      p0_valid = 1'b0; p1_valid = 1'b0;
      #1;
      chk("rr_level", 32'(level), 5);
      chk("hold_m_data", 32'(m_data), 32'h5);

      // 3. fill to full with p0 held valid
      p0_valid = 1'b1; p0_data = 4'h9;
      exp_lvl = 5;
      for (int i = 0; i < 5; i++) begin
         #1;
         er = (exp_lvl < 8);
         chk("fill_p0_ready", 32'(p0_ready), 32'(er));
         chk("fill_wr_en", 32'(fifo_wr_en), 32'(er));
         if (er) begin
            sb.push_back(4'h9);
            exp_lvl++;
         end
         $display("fill cycle %0d: level=%0d", i, level);
         tick();
      end
      p1_valid = 1'b1; p1_data = 4'hE;
      #1;
      chk("full_p0_ready", 32'(p0_ready), 0);
      chk("full_p1_ready", 32'(p1_ready), 0);
      chk("full_level", 32'(level), 8);
      chk("full_sync_err", 32'(sync_err), 0);
      p0_valid = 1'b0; p1_valid = 1'b0;

      // 4. drain with a three-cycle stall
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_m_valid", 32'(m_valid), 1);
         chk("stall_m_data", 32'(m_data), 32'h5);
         chk("stall_rd_en", 32'(fifo_rd_en), 0);
         tick();
      end
      m_ready = 1'b1;
      #1;
      chk("hs_rd_en", 32'(fifo_rd_en), 1);
      tick();
      #1;
      chk("fetch_m_valid", 32'(m_valid), 0);
      tick();
      #1;
      chk("next_m_valid", 32'(m_valid), 1);
      chk("next_m_data", 32'(m_data), 32'h6);
      for (guard = 0; guard < 60; guard++) begin
         if (sb.size() == 0 && level == 0 && m_valid == 1'b0) break;
         tick();
      end
      #1;
      chk("drain_bound", 32'(guard < 60), 1);
      chk("drain_level", 32'(level), 0);
      chk("drain_m_valid", 32'(m_valid), 0);
      chk("empty_rd_en", 32'(fifo_rd_en), 0);
      chk("drain_sb", 32'(sb.size()), 0);
      chk("drain_sync_err", 32'(sync_err), 0);

      // 5. simultaneous write and read at level 3, then ena drop in HOLD
      m_ready = 1'b0; p0_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         p0_data = 4'(i);
         #1;
         chk("l3_wr_en", 32'(fifo_wr_en), 1);
         sb.push_back(4'(i));
         tick();
      end
      #1;
      chk("l3_level", 32'(level), 3);
      chk("l3_m_data", 32'(m_data), 32'h1);
      p0_data = 4'h5; m_ready = 1'b1;
      #1;
      chk("sim_wr_en", 32'(fifo_wr_en), 1);
      chk("sim_rd_en", 32'(fifo_rd_en), 1);
      sb.push_back(4'h5);
      tick();
      p0_valid = 1'b0; m_ready = 1'b0;
      #1;
      chk("sim_level", 32'(level), 3);
      tick();
      ena = 1'b0;
      #1;
      chk("ena0_m_valid", 32'(m_valid), 1);
      chk("ena0_m_data", 32'(m_data), 32'h2);
      m_ready = 1'b1;
      #1;
      chk("ena0_rd_en", 32'(fifo_rd_en), 0);
      tick();
      #1;
      chk("ena0_after_valid", 32'(m_valid), 0);
      tick();
      #1;
      chk("ena0_idle_rd_en", 32'(fifo_rd_en), 0);
      chk("ena0_level", 32'(level), 3);
      m_ready = 1'b0;

      // 6. flag mismatch, then async reset mid-FETCH
      ena = 1'b1;
      tick(); tick();
      #1;
      chk("mm_level", 32'(level), 2);
      chk("mm_pre_err", 32'(sync_err), 0);
      fe_force = 1'b1; fe_val = 1'b1;
      tick();
      fe_force = 1'b0;
      #1;
      chk("mm_set", 32'(sync_err), 1);
      tick(); tick();
      #1;
      chk("mm_sticky", 32'(sync_err), 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0; p0_valid = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("arst_m_valid", 32'(m_valid), 0);
      chk("arst_sync_err", 32'(sync_err), 0);
      chk("arst_level", 32'(level), 0);
      chk("arst_p0_ready", 32'(p0_ready), 0);
      chk("arst_rd_en", 32'(fifo_rd_en), 0);
      tick();
      #1;
      chk("arst_discard", 32'(m_valid), 0);
      p0_valid = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      tick();
      #1;
      chk("post_rst_m_valid", 32'(m_valid), 0);
      chk("post_rst_m_data", 32'(m_data), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
